mmcm_drp_reconfig: RTL and testbench
====================================

Name: mmcm_drp_reconfig

Overview:
- Sequences one dynamic reconfiguration of an MMCM through its DRP port.
- On a start request it holds the MMCM in reset and performs a read-modify-write of every register entry of the selected configuration.
- It then releases the MMCM reset and waits for LOCKED, reporting done or error.
- It sits between the clocking control logic and the MMCM DRP; the configuration table lives in an external registered ROM.

Parameters:
NUM_CFG, 2, number of selectable configurations (SADDR width CFG_W = clog2(NUM_CFG), min 1)
REGS_PER_CFG, 23, ROM entries per configuration
ROM_AW, 6, ROM address width; must satisfy NUM_CFG*REGS_PER_CFG <= 2^ROM_AW
DRP_TIMEOUT, 255, max cycles waiting for DRDY after a DEN pulse
LOCK_TIMEOUT, 16383, max cycles waiting for LOCKED after MMCM reset release

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
SEN  in  1  start request, single-cycle pulse, sampled only in IDLE
SADDR  in  CFG_W  configuration index, captured with SEN
BUSY  out  1  high from the cycle after an accepted SEN until the SRDY/ERR cycle
SRDY  out  1  one-cycle pulse: reconfiguration finished and LOCKED seen
ERR  out  1  one-cycle pulse: DRP or lock timeout, or SADDR >= NUM_CFG
ROM_ADDR  out  ROM_AW  ROM read address
ROM_DATA  in  39  {addr[38:32], mask[31:16], data[15:0]}, valid 1 cycle after ROM_ADDR
DADDR  out  7  DRP address
DI  out  16  DRP write data
DO  in  16  DRP read data, valid with DRDY
DEN  out  1  DRP enable, one-cycle pulse
DWE  out  1  DRP write enable, asserted only together with DEN
DRDY  in  1  DRP ready
RST_MMCM  out  1  MMCM reset
LOCKED  in  1  MMCM locked

Behaviour:
- Reset: all outputs are 0; state is IDLE; index and timers are cleared. RST asserted mid-operation aborts immediately; RST_MMCM drops the next cycle. There is no recovery; the requester must re-issue SEN. RST wins over SEN in the same cycle.
- Base address: base = SADDR*REGS_PER_CFG, computed at ROM_AW width. Entry index idx counts 0..REGS_PER_CFG-1. ROM_ADDR = base + idx.
- State IDLE: on SEN with SADDR < NUM_CFG, latch SADDR, set idx=0, assert BUSY and RST_MMCM, go to FETCH. On SEN with SADDR >= NUM_CFG, pulse ERR for 1 cycle, stay IDLE, BUSY stays 0. SEN outside IDLE is ignored.
- State FETCH: ROM_ADDR is driven. Wait exactly 1 cycle. Latch ROM_DATA into addr/mask/data registers. Go to READ.
- State READ: DEN=1, DWE=0, DADDR=addr for one cycle. Go to WAIT_RD.
- State WAIT_RD: on DRDY, compute DI = (DO & mask) | (data & ~mask). Mask bit 1 keeps the old bit. Go to WRITE.
- State WRITE: DEN=1, DWE=1, DADDR=addr, DI held for one cycle. Go to WAIT_WR.
- State WAIT_WR: on DRDY, if idx == REGS_PER_CFG-1 go to RELEASE; else idx+1 and go to FETCH.
- State RELEASE: deassert RST_MMCM, clear timer, go to WAIT_LOCK.
- State WAIT_LOCK: on LOCKED=1, pulse SRDY, drop BUSY, go to IDLE.
- DRP timer: counts in WAIT_RD/WAIT_WR; it is cleared on each DEN. Reaching DRP_TIMEOUT without DRDY gives an ERR pulse, deasserts RST_MMCM, drops BUSY, and returns to IDLE.
- Lock timer: reaching LOCK_TIMEOUT in WAIT_LOCK gives an ERR pulse, drops BUSY, and returns to IDLE.
- LOCKED is ignored in all states except WAIT_LOCK.
- DRDY arriving outside WAIT_RD/WAIT_WR is ignored. DRDY in the same cycle as DEN is not accepted; the earliest accepted DRDY is the cycle after DEN.
- Exactly one DEN is issued per READ or WRITE. DEN is never asserted while a DRP access is outstanding.
- RST_MMCM is high continuously from the cycle after SEN acceptance through the last WAIT_WR DRDY cycle.
- Timing: with ideal DRDY (1 cycle after DEN), each entry takes 6 cycles, giving 6*REGS_PER_CFG + 2 cycles from SEN to WAIT_LOCK.

Test Plan:
- NUM_CFG=2, REGS_PER_CFG=3, DRDY 1 cycle after DEN; SEN with SADDR=1 -> ROM_ADDR 3,4,5 in order; 3 reads then 3 writes interleaved. Entry {addr=0x08, mask=0x1000, data=0x0145} with DO=0xFFFF gives DI=0x1145. SRDY 1 cycle after LOCKED.
- RST_MMCM check -> high throughout all DRP traffic, low in WAIT_LOCK. LOCKED pulsed high during the write phase -> ignored, no SRDY.
- SEN with SADDR=2 (NUM_CFG=2) -> single ERR pulse; BUSY, DEN and RST_MMCM stay 0.
- DRDY withheld on 2nd read, DRP_TIMEOUT=8 -> ERR exactly 8 cycles after wait start; BUSY=0 and RST_MMCM=0 afterwards.
- LOCKED never asserted, LOCK_TIMEOUT=20 -> ERR 20 cycles after RELEASE. A following SEN with SADDR=0 completes normally (ROM_ADDR 0,1,2).
- RST during WAIT_WR, with SEN pulsed while BUSY -> all outputs 0 the next cycle and the in-flight SEN is ignored. A new SEN restarts at idx=0.

Source files
------------

// File: rtl/mmcm_drp_reconfig.sv
// mmcm_drp_reconfig
//   Sequences one dynamic reconfiguration of an MMCM through its DRP port.
//   On an accepted start request the MMCM is held in reset while every ROM entry of the
//   selected configuration is applied as a DRP read-modify-write. The MMCM reset is then
//   released and the block waits for LOCKED, reporting SRDY (success) or ERR (timeout).
//
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   SEN, SADDR        start pulse and configuration index (sampled only when idle)
//   BUSY, SRDY, ERR   status: busy level, done pulse, error pulse
//   ROM_ADDR/ROM_DATA external registered ROM, {addr[38:32], mask[31:16], data[15:0]}
//   DADDR, DI, DO     DRP address, write data, read data
//   DEN, DWE, DRDY    DRP enable/write-enable pulses and ready
//   RST_MMCM, LOCKED  MMCM reset and lock status
module mmcm_drp_reconfig #(
    parameter int unsigned NUM_CFG      = 2,
    parameter int unsigned REGS_PER_CFG = 23,
    parameter int unsigned ROM_AW       = 6,
    parameter int unsigned DRP_TIMEOUT  = 255,
    parameter int unsigned LOCK_TIMEOUT = 16383,
    parameter int unsigned CFG_W        = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SEN,
    input  logic [CFG_W-1:0]  SADDR,
    output logic              BUSY,
    output logic              SRDY,
    output logic              ERR,
    output logic [ROM_AW-1:0] ROM_ADDR,
    input  logic [38:0]       ROM_DATA,
    output logic [6:0]        DADDR,
    output logic [15:0]       DI,
    input  logic [15:0]       DO,
    output logic              DEN,
    output logic              DWE,
    input  logic              DRDY,
    output logic              RST_MMCM,
    input  logic              LOCKED
);

    localparam int unsigned IdxW   = (REGS_PER_CFG > 1) ? $clog2(REGS_PER_CFG) : 1;
    localparam int unsigned TmrMax = (DRP_TIMEOUT > LOCK_TIMEOUT) ? DRP_TIMEOUT : LOCK_TIMEOUT;
    localparam int unsigned TmrW   = $clog2(TmrMax + 1);

    localparam logic [IdxW-1:0] IdxLast  = IdxW'(REGS_PER_CFG - 1);
    localparam logic [TmrW-1:0] DrpLast  = TmrW'(DRP_TIMEOUT - 1);
    localparam logic [TmrW-1:0] LockLast = TmrW'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StRead,
        StWaitRd,
        StWrite,
        StWaitWr,
        StRelease,
        StWaitLock
    } state_e;

    state_e            state_q;
    logic [CFG_W-1:0]  cfg_q;
    logic [IdxW-1:0]   idx_q;
    logic              fetch_wait_q;
    logic [TmrW-1:0]   tmr_q;
    logic [6:0]        addr_q;
    logic [15:0]       mask_q;
    logic [15:0]       data_q;
    logic [15:0]       di_q;
    logic [ROM_AW-1:0] rom_addr_q;
    logic              busy_q;
    logic              srdy_q;
    logic              err_q;
    logic              den_q;
    logic              dwe_q;
    logic              rst_mmcm_q;

    logic [ROM_AW-1:0] base_sen;
    logic [ROM_AW-1:0] base_cur;
    logic [IdxW-1:0]   idx_d;
    logic [ROM_AW-1:0] rom_addr_d;
    logic [15:0]       di_d;
    logic              sen_ok;

    always_comb begin
        base_sen   = ROM_AW'(SADDR) * ROM_AW'(REGS_PER_CFG);
        base_cur   = ROM_AW'(cfg_q) * ROM_AW'(REGS_PER_CFG);
        idx_d      = idx_q + 1'b1;
        rom_addr_d = base_cur + ROM_AW'(idx_d);
        // Mask bit set keeps the bit read back from the MMCM.
        di_d       = (DO & mask_q) | (data_q & ~mask_q);
        sen_ok     = 32'(SADDR) < NUM_CFG;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            cfg_q        <= '0;
            idx_q        <= '0;
            fetch_wait_q <= 1'b0;
            tmr_q        <= '0;
            addr_q       <= '0;
            mask_q       <= '0;
            data_q       <= '0;
            di_q         <= '0;
            rom_addr_q   <= '0;
            busy_q       <= 1'b0;
            srdy_q       <= 1'b0;
            err_q        <= 1'b0;
            den_q        <= 1'b0;
            dwe_q        <= 1'b0;
            rst_mmcm_q   <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            den_q  <= 1'b0;
            dwe_q  <= 1'b0;
            srdy_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (SEN) begin
                        if (sen_ok) begin
                            cfg_q        <= SADDR;
                            idx_q        <= '0;
                            fetch_wait_q <= 1'b0;
                            rom_addr_q   <= base_sen;
                            busy_q       <= 1'b1;
                            rst_mmcm_q   <= 1'b1;
                            state_q      <= StFetch;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StFetch: begin
                    // First cycle presents ROM_ADDR, second cycle sees the registered data.
                    if (!fetch_wait_q) begin
                        fetch_wait_q <= 1'b1;
                    end else begin
                        fetch_wait_q <= 1'b0;
                        addr_q       <= ROM_DATA[38:32];
                        mask_q       <= ROM_DATA[31:16];
                        data_q       <= ROM_DATA[15:0];
                        den_q        <= 1'b1;
                        state_q      <= StRead;
                    end
                end
                StRead: begin
                    tmr_q   <= '0;
                    state_q <= StWaitRd;
                end
                StWaitRd: begin
                    if (DRDY) begin
                        di_q    <= di_d;
                        den_q   <= 1'b1;
                        dwe_q   <= 1'b1;
                        state_q <= StWrite;
                    end else if (tmr_q == DrpLast) begin
                        err_q      <= 1'b1;
                        busy_q     <= 1'b0;
                        rst_mmcm_q <= 1'b0;
                        state_q    <= StIdle;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                StWrite: begin
                    tmr_q   <= '0;
                    state_q <= StWaitWr;
                end
                StWaitWr: begin
                    if (DRDY) begin
                        if (idx_q == IdxLast) begin
                            rst_mmcm_q <= 1'b0;
                            state_q    <= StRelease;
                        end else begin
                            idx_q      <= idx_d;
                            rom_addr_q <= rom_addr_d;
                            state_q    <= StFetch;
                        end
                    end else if (tmr_q == DrpLast) begin
                        err_q      <= 1'b1;
                        busy_q     <= 1'b0;
                        rst_mmcm_q <= 1'b0;
                        state_q    <= StIdle;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                StRelease: begin
                    tmr_q   <= '0;
                    state_q <= StWaitLock;
                end
                StWaitLock: begin
                    if (LOCKED) begin
                        srdy_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (tmr_q == LockLast) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign BUSY     = busy_q;
    assign SRDY     = srdy_q;
    assign ERR      = err_q;
    assign ROM_ADDR = rom_addr_q;
    assign DADDR    = addr_q;
    assign DI       = di_q;
    assign DEN      = den_q;
    assign DWE      = dwe_q;
    assign RST_MMCM = rst_mmcm_q;

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Testbench for mmcm_drp_reconfig: registered ROM model, DRP slave model and a scoreboard.
// Stimulus pushes the expected DRP accesses and SRDY/ERR pulses (with the cycle they must
// appear in); a negedge monitor pops and compares each one the DUT actually presents.
module tb_mmcm_drp_reconfig;

    logic        CLK;
    logic        RST;
    logic        SEN;
    logic [1:0]  SADDR;
    logic        BUSY;
    logic        SRDY;
    logic        ERR;
    logic [5:0]  ROM_ADDR;
    logic [38:0] ROM_DATA;
    logic [6:0]  DADDR;
    logic [15:0] DI;
    logic [15:0] DO;
    logic        DEN;
    logic        DWE;
    logic        DRDY;
    logic        RST_MMCM;
    logic        LOCKED;

    mmcm_drp_reconfig #(
        .NUM_CFG      (2),
        .REGS_PER_CFG (3),
        .ROM_AW       (6),
        .DRP_TIMEOUT  (8),
        .LOCK_TIMEOUT (20),
        .CFG_W        (2)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .SEN      (SEN),
        .SADDR    (SADDR),
        .BUSY     (BUSY),
        .SRDY     (SRDY),
        .ERR      (ERR),
        .ROM_ADDR (ROM_ADDR),
        .ROM_DATA (ROM_DATA),
        .DADDR    (DADDR),
        .DI       (DI),
        .DO       (DO),
        .DEN      (DEN),
        .DWE      (DWE),
        .DRDY     (DRDY),
        .RST_MMCM (RST_MMCM),
        .LOCKED   (LOCKED)
    );

    // kind: 0 = DRP access (DEN), 1 = SRDY, 2 = ERR
    typedef struct {
        int          kind;
        int          cyc;
        logic        we;
        logic [6:0]  addr;
        logic [15:0] di;
        logic [5:0]  rom;
        logic        busy;
        logic        rmm;
    } ev_t;

    ev_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        hold = 1'b0;
    logic [38:0] rom [0:63];
    logic [15:0] drp_mem [0:127];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Registered ROM: data for the address of cycle k appears in cycle k+1.
    initial begin
        logic [38:0] rom_next;
        rom_next = '0;
        ROM_DATA = '0;
        forever begin
            @(posedge CLK);
            #1;
            ROM_DATA = rom_next;
            rom_next = rom[ROM_ADDR];
        end
    end

    // DRP slave: DRDY exactly one cycle after DEN unless hold is set.
    initial begin
        logic        pend;
        logic [15:0] pend_do;
        pend    = 1'b0;
        pend_do = '0;
        DRDY    = 1'b0;
        DO      = '0;
        forever begin
            @(posedge CLK);
            #1;
            DRDY = pend;
            DO   = pend ? pend_do : 16'h0000;
            pend = 1'b0;
            if (DEN && !hold) begin
                pend    = 1'b1;
                pend_do = drp_mem[DADDR];
                if (DWE) drp_mem[DADDR] = DI;
            end
        end
    end

    // Monitor / scoreboard.
    initial forever begin
        @(negedge CLK);
        if (DWE) begin
            checks++;
            if (!DEN) begin
                errors++;
                $display("FAIL dwe_without_den: cyc=%0d DWE=1 DEN=0, want DEN=1", cyc);
            end
        end
        if (DEN || SRDY || ERR) begin
            int  k;
            bit  ok;
            ev_t e;
            k = DEN ? 0 : (SRDY ? 1 : 2);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: kind=%0d cyc=%0d DADDR=%0h, want none", k, cyc,
                         DADDR);
            end else begin
                e  = exp_q.pop_front();
                ok = (k == e.kind) && (cyc == e.cyc) && (BUSY == e.busy) && (RST_MMCM == e.rmm);
                if (e.kind == 0) begin
                    ok = ok && (DWE == e.we) && (DADDR == e.addr) && (ROM_ADDR == e.rom);
                    if (e.we) ok = ok && (DI == e.di);
                end
                if (!ok) begin
                    errors++;
                    $display({"FAIL event: got kind=%0d cyc=%0d we=%0b addr=%0h di=%0h rom=%0d ",
                              "busy=%0b rst_mmcm=%0b, want kind=%0d cyc=%0d we=%0b addr=%0h ",
                              "di=%0h rom=%0d busy=%0b rst_mmcm=%0b"},
                             k, cyc, DWE, DADDR, DI, ROM_ADDR, BUSY, RST_MMCM,
                             e.kind, e.cyc, e.we, e.addr, e.di, e.rom, e.busy, e.rmm);
                end
            end
        end
    end

    task automatic push_drp(input int t, input logic we, input logic [6:0] a,
                            input logic [15:0] d, input logic [5:0] r);
        ev_t e;
        e.kind = 0;
        e.cyc  = t;
        e.we   = we;
        e.addr = a;
        e.di   = d;
        e.rom  = r;
        e.busy = 1'b1;
        e.rmm  = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic push_end(input int k, input int t);
        ev_t e;
        e.kind = k;
        e.cyc  = t;
        e.we   = 1'b0;
        e.addr = '0;
        e.di   = '0;
        e.rom  = '0;
        e.busy = 1'b0;
        e.rmm  = 1'b0;
        exp_q.push_back(e);
    endtask

    // Entry e of a run started in cycle c: READ at c+3+6e, WRITE at c+5+6e.
    task automatic push_entry(input int c, input int e, input logic [6:0] a,
                              input logic [15:0] d, input logic [5:0] r);
        push_drp(c + 3 + 6 * e, 1'b0, a, 16'h0000, r);
        push_drp(c + 5 + 6 * e, 1'b1, a, d, r);
    endtask

    task automatic push_cfg1(input int c);
        push_entry(c, 0, 7'h08, 16'h1145, 6'd3);
        push_entry(c, 1, 7'h10, 16'h12AB, 6'd4);
        push_entry(c, 2, 7'h2A, 16'hBEEF, 6'd5);
    endtask

    task automatic push_cfg0(input int c);
        push_entry(c, 0, 7'h01, 16'hA511, 6'd0);
        push_entry(c, 1, 7'h02, 16'h330F, 6'd1);
        push_entry(c, 2, 7'h03, 16'hCAFE, 6'd2);
    endtask

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", n, got, want);
        end
    endtask

    task automatic drain(input string n);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected events never seen, want 0", n, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic start(input logic [1:0] s, output int c);
        c     = cyc;
        SEN   = 1'b1;
        SADDR = s;
    endtask

    // Full successful run: LOCKED raised in cycle c+22, SRDY expected in c+23.
    task automatic run_ok(input logic [1:0] s, input string n);
        int c;
        start(s, c);
        if (s == 2'd1) push_cfg1(c);
        else push_cfg0(c);
        push_end(1, c + 23);
        goto(c + 1);
        SEN = 1'b0;
        goto(c + 22);
        LOCKED = 1'b1;
        goto(c + 26);
        LOCKED = 1'b0;
        drain(n);
    endtask

    initial begin
        int c;
        RST    = 1'b1;
        SEN    = 1'b0;
        SADDR  = 2'd0;
        LOCKED = 1'b0;
        for (int i = 0; i < 64; i++) rom[i] = '0;
        for (int i = 0; i < 128; i++) drp_mem[i] = '0;
        rom[0] = {7'h01, 16'hFF00, 16'h0011};
        rom[1] = {7'h02, 16'h00FF, 16'h3300};
        rom[2] = {7'h03, 16'hFFFF, 16'h1234};
        rom[3] = {7'h08, 16'h1000, 16'h0145};
        rom[4] = {7'h10, 16'hFF00, 16'h00AB};
        rom[5] = {7'h2A, 16'h0000, 16'hBEEF};
        drp_mem[7'h08] = 16'hFFFF;
        drp_mem[7'h10] = 16'h1234;
        drp_mem[7'h2A] = 16'h5555;
        drp_mem[7'h01] = 16'hA5A5;
        drp_mem[7'h02] = 16'h0F0F;
        drp_mem[7'h03] = 16'hCAFE;

        goto(3);
        chk("reset_outputs", 64'({BUSY, SRDY, ERR, ROM_ADDR, DADDR, DI, DEN, DWE, RST_MMCM}),
            64'h0);
        RST = 1'b0;
        goto(5);

        // Config 1, ideal DRDY, stray LOCKED pulse during entry 1 WRITE.
        start(2'd1, c);
        push_cfg1(c);
        push_end(1, c + 23);
        goto(c + 1);
        SEN = 1'b0;
        chk("rst_mmcm_fetch", 64'(RST_MMCM), 64'h1);
        goto(c + 11);
        LOCKED = 1'b1;
        goto(c + 12);
        LOCKED = 1'b0;
        goto(c + 18);
        chk("rst_mmcm_last_wait_wr", 64'(RST_MMCM), 64'h1);
        goto(c + 20);
        chk("wait_lock_busy_rst", 64'({BUSY, RST_MMCM}), 64'h2);
        goto(c + 22);
        LOCKED = 1'b1;
        goto(c + 26);
        LOCKED = 1'b0;
        drain("cfg1_run");

        // Out-of-range index: single ERR, nothing else moves.
        start(2'd2, c);
        push_end(2, c + 1);
        goto(c + 1);
        SEN = 1'b0;
        chk("bad_saddr_busy_rst", 64'({BUSY, RST_MMCM}), 64'h0);
        goto(c + 2);
        chk("bad_saddr_err_single", 64'({ERR, BUSY}), 64'h0);
        goto(c + 6);
        drain("bad_saddr");

        // DRDY withheld on the second read: ERR 8 cycles after WAIT_RD starts (c+10).
        start(2'd0, c);
        push_entry(c, 0, 7'h01, 16'hA511, 6'd0);
        push_drp(c + 9, 1'b0, 7'h02, 16'h0000, 6'd1);
        push_end(2, c + 18);
        goto(c + 1);
        SEN = 1'b0;
        goto(c + 7);
        hold = 1'b1;
        goto(c + 19);
        chk("drp_timeout_after", 64'({BUSY, RST_MMCM}), 64'h0);
        hold = 1'b0;
        goto(c + 24);
        drain("drp_timeout");

        // LOCKED never rises: ERR after 20 WAIT_LOCK cycles (c+20 .. c+39).
        start(2'd1, c);
        push_cfg1(c);
        push_end(2, c + 40);
        goto(c + 1);
        SEN = 1'b0;
        goto(c + 39);
        chk("lock_wait_busy", 64'(BUSY), 64'h1);
        goto(c + 44);
        drain("lock_timeout");
        run_ok(2'd0, "cfg0_after_lock_timeout");

        // RST during entry 0 WAIT_WR, SEN pulsed while busy and together with RST.
        start(2'd1, c);
        push_entry(c, 0, 7'h08, 16'h1145, 6'd3);
        goto(c + 1);
        SEN = 1'b0;
        goto(c + 4);
        SEN   = 1'b1;
        SADDR = 2'd0;
        goto(c + 5);
        SEN = 1'b0;
        goto(c + 6);
        RST = 1'b1;
        SEN = 1'b1;
        goto(c + 7);
        RST = 1'b0;
        SEN = 1'b0;
        chk("abort_outputs", 64'({BUSY, SRDY, ERR, ROM_ADDR, DADDR, DI, DEN, DWE, RST_MMCM}),
            64'h0);
        goto(c + 12);
        chk("abort_stays_idle", 64'({BUSY, RST_MMCM}), 64'h0);
        drain("abort");
        run_ok(2'd1, "restart_after_abort");

        goto(cyc + 3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
